// File: rtl/snn_pkg.sv
// Shared SNN constants and types.
// Default channel count/width and the spike vector type for the network input.
package snn_pkg;

  localparam int SNN_NUM_IN = 3;
  localparam int SNN_INT_W  = 4;

  typedef logic [SNN_NUM_IN-1:0] spike_vec_t;

endpackage

// File: rtl/spike_enc_channel.sv
// One rate-coding channel: intensity register, phase accumulator, spike flop.
// Ports: clk, rst_n, i_tick (accumulate strobe), i_wr (intensity load),
//   i_intensity, o_spike (one-cycle pulse after a carry-out tick).
// Option: SPIKE_ENC_REFRACTORY_EN adds a per-channel hold-off counter.
module spike_enc_channel
  import snn_pkg::*;
#(
  parameter int INT_W        = SNN_INT_W,
  parameter int REFRAC_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_wr,
  input  logic [INT_W-1:0] i_intensity,
  output logic             o_spike
);

  logic [INT_W-1:0] r_int;
  logic [INT_W-1:0] r_acc;
  logic             r_spike;
  logic [INT_W:0]   w_sum;

  assign w_sum   = {1'b0, r_acc} + {1'b0, r_int};
  assign o_spike = r_spike;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int <= '0;
    end else if (i_wr) begin
      r_int <= i_intensity;
    end
  end

`ifdef SPIKE_ENC_REFRACTORY_EN
  localparam int RC_W = (REFRAC_TICKS > 0) ?
                        $clog2(REFRAC_TICKS + 1) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRAC_TICKS);

  logic [RC_W-1:0] r_rcnt;

  // While holding off, ticks only count down; phase is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_spike <= 1'b0;
      r_rcnt  <= '0;
    end else begin
      r_spike <= 1'b0;
      if (i_tick) begin
        if (r_rcnt != '0) begin
          r_rcnt <= r_rcnt - 1'b1;
        end else begin
          r_acc   <= w_sum[INT_W-1:0];
          r_spike <= w_sum[INT_W];
          if (w_sum[INT_W]) begin
            r_rcnt <= RC_LOAD;
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_spike <= 1'b0;
      if (i_tick) begin
        r_acc   <= w_sum[INT_W-1:0];
        r_spike <= w_sum[INT_W];
      end
    end
  end
`endif

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: shared tick prescaler, intensity write handshake, NUM_CH channels.
// Ports: clk, rst_n, enable, prescale, cfg_valid/cfg_ready/cfg_ch/cfg_intensity,
//   spike_out (per-channel pulses), tick_out (registered tick strobe).
// Option: SPIKE_ENC_REFRACTORY_EN enables refractory hold-off in each channel.
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int NUM_CH       = SNN_NUM_IN,
  parameter int INT_W        = SNN_INT_W,
  parameter int PRESCALE_W   = 8,
  parameter int REFRAC_TICKS = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [INT_W-1:0]      cfg_intensity,
  output logic [NUM_CH-1:0]     spike_out,
  output logic                  tick_out
);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic                  r_tick;
  logic                  w_tick;
  logic                  w_accept;
  logic [NUM_CH-1:0]     w_wr;

  // Writes are refused on the tick cycle so they never race an accumulate.
  assign w_tick    = enable && (r_pcnt == prescale);
  assign cfg_ready = !w_tick;
  assign w_accept  = cfg_valid && !w_tick;
  assign tick_out  = r_tick;

  // Equality compare: a lowered prescale below pcnt lets it run to wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (enable) begin
        r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
      end
    end
  end

  // Out-of-range cfg_ch matches no channel, so the write is dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = w_accept && (cfg_ch == CH_W'(g));

    spike_enc_channel #(
      .INT_W        (INT_W),
      .REFRAC_TICKS (REFRAC_TICKS)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_tick      (w_tick),
      .i_wr        (w_wr[g]),
      .i_intensity (cfg_intensity),
      .o_spike     (spike_out[g])
    );
  end

endmodule
